// File: rtl/cache_ctrl_pkg.sv
// lc3b_types: shared cache control types (FSM state, way index, way count)
package lc3b_types;
  typedef enum logic [1:0] {CHECK, WRITEBACK, ALLOCATE} cache_ctrl_state_t;
  typedef logic lc3b_way;
  localparam int CACHE_WAYS = 2;
endpackage

// File: rtl/cache_ctrl_perf_cnt.sv
// cache_perf_cnt: enable-gated wrapping counter
// Ports: clk, reset_n (async active-low), en (count this cycle), count (W-bit value)
module cache_perf_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (en) count <= count + W'(1);
endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: control FSM for the 2-way set-associative L1 cache datapath
// Ports: clk, reset_n (async active-low); CPU side mem_read/mem_write/mem_resp;
//   datapath status hit, lru_way, victim_dirty; pmem_read/pmem_write/pmem_resp;
//   array enables data/tag/valid/dirty_write, dirty_in, lru_write, lru_in;
//   mux selects way_sel, data_src_sel, pmem_addr_sel; hit/miss/wb_count.
// Macro CACHE_CTRL_PERF_EN enables the performance counters (tied 0 otherwise).
module cache_ctrl
  import lc3b_types::*;
#(
  parameter int INDEX_WIDTH = 3,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic                  mem_resp,
  input  logic [CACHE_WAYS-1:0] hit,
  input  logic                  lru_way,
  input  logic                  victim_dirty,
  output logic                  pmem_read,
  output logic                  pmem_write,
  input  logic                  pmem_resp,
  output logic [CACHE_WAYS-1:0] data_write,
  output logic [CACHE_WAYS-1:0] tag_write,
  output logic [CACHE_WAYS-1:0] valid_write,
  output logic [CACHE_WAYS-1:0] dirty_write,
  output logic                  dirty_in,
  output logic                  lru_write,
  output logic                  lru_in,
  output logic                  way_sel,
  output logic                  data_src_sel,
  output logic                  pmem_addr_sel,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count,
  output logic [CNT_WIDTH-1:0]  wb_count
);
  if (INDEX_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_param
    $error("cache_ctrl: INDEX_WIDTH and CNT_WIDTH must be positive");
  end
  cache_ctrl_state_t state, next;
  lc3b_way victim_q, w;
  logic req, is_hit;
  assign req    = mem_read | mem_write;
  assign is_hit = |hit;
  // hit=2'b11 is illegal; way 0 takes priority
  assign w = ~hit[0];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= CHECK;
      victim_q <= 1'b0;
    end else begin
      state <= next;
      if (state == CHECK && req && !is_hit) victim_q <= lru_way;
    end
  // Everything is held at 0 while reset_n is low so no strobe leaks out during reset
  always_comb begin
    next          = state;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    data_write    = '0;
    tag_write     = '0;
    valid_write   = '0;
    dirty_write   = '0;
    dirty_in      = 1'b0;
    lru_write     = 1'b0;
    lru_in        = 1'b0;
    way_sel       = 1'b0;
    data_src_sel  = 1'b0;
    pmem_addr_sel = 1'b0;
    if (reset_n)
      unique case (state)
        CHECK: begin
          way_sel = lru_way;
          if (req && is_hit) begin
            mem_resp  = 1'b1;
            way_sel   = w;
            lru_write = 1'b1;
            lru_in    = ~w;
            if (mem_write) begin
              data_write[w]  = 1'b1;
              dirty_write[w] = 1'b1;
              dirty_in       = 1'b1;
            end
          end else if (req) next = victim_dirty ? WRITEBACK : ALLOCATE;
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          way_sel       = victim_q;
          next          = pmem_resp ? ALLOCATE : WRITEBACK;
        end
        ALLOCATE: begin
          pmem_read = 1'b1;
          way_sel   = victim_q;
          if (pmem_resp) begin
            data_write[victim_q]  = 1'b1;
            tag_write[victim_q]   = 1'b1;
            valid_write[victim_q] = 1'b1;
            dirty_write[victim_q] = 1'b1;
            data_src_sel          = 1'b1;
            next                  = CHECK;
          end
        end
        default: next = CHECK;
      endcase
  end
`ifdef CACHE_CTRL_PERF_EN
  cache_perf_cnt #(.W(CNT_WIDTH)) u_hit_cnt (
    .clk(clk), .reset_n(reset_n), .en(state == CHECK && req && is_hit), .count(hit_count));
  cache_perf_cnt #(.W(CNT_WIDTH)) u_miss_cnt (
    .clk(clk), .reset_n(reset_n), .en(state == CHECK && req && !is_hit), .count(miss_count));
  cache_perf_cnt #(.W(CNT_WIDTH)) u_wb_cnt (
    .clk(clk), .reset_n(reset_n), .en(state == WRITEBACK && pmem_resp), .count(wb_count));
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed self-checking bench for cache_ctrl
module tb_cache_ctrl;
`ifdef CACHE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0;
  logic mem_read = 1'b0, mem_write = 1'b0, lru_way = 1'b0, victim_dirty = 1'b0, pmem_resp = 1'b0;
  logic [1:0] hit = 2'b00;
  logic mem_resp, pmem_read, pmem_write, dirty_in, lru_write, lru_in, way_sel, data_src_sel, pmem_addr_sel;
  logic [1:0] data_write, tag_write, valid_write, dirty_write;
  logic [15:0] hit_count, miss_count, wb_count;
  int errors = 0, checks = 0, cyc;
  int n_hit = 0, n_miss = 0, n_wb = 0;
  logic [16:0] e;
  logic [47:0] ec;
  wire [16:0] outs = {mem_resp, pmem_read, pmem_write, data_write, tag_write, valid_write,
                      dirty_write, dirty_in, lru_write, lru_in, way_sel, data_src_sel, pmem_addr_sel};
  wire [47:0] cnts = {hit_count, miss_count, wb_count};
  always #5 clk = ~clk;
  cache_ctrl dut (
    .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit(hit), .lru_way(lru_way), .victim_dirty(victim_dirty), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_resp(pmem_resp), .data_write(data_write), .tag_write(tag_write),
    .valid_write(valid_write), .dirty_write(dirty_write), .dirty_in(dirty_in), .lru_write(lru_write),
    .lru_in(lru_in), .way_sel(way_sel), .data_src_sel(data_src_sel), .pmem_addr_sel(pmem_addr_sel),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count));
  // bit order: resp pread pwrite dw[2] tw[2] vw[2] yw[2] din lruw lruin way src asel
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    mem_read = 1'b1; hit = 2'b01;
    #2;
    e = 17'b0; checks++;
    if (outs !== e) begin errors++; $display("FAIL reset_outs got=%b want=%b", outs, e); end
    checks++;
    if (cnts !== 48'h0) begin errors++; $display("FAIL reset_cnts got=%h want=0", cnts); end
    tick;
    mem_read = 1'b0; hit = 2'b00; reset_n = 1'b1;
    lru_way = 1'b1;
    #1;
    e = 17'b0_0_0_00_00_00_00_0_0_0_1_0_0; checks++;
    if (outs !== e) begin errors++; $display("FAIL idle got=%b want=%b", outs, e); end
  endtask
  task automatic test_read_hit;
    lru_way = 1'b0; mem_read = 1'b1; hit = 2'b10;
    #1;
    e = 17'b1_0_0_00_00_00_00_0_1_0_1_0_0; checks++;
    if (outs !== e) begin errors++; $display("FAIL read_hit got=%b want=%b", outs, e); end
    tick; n_hit++;
    mem_read = 1'b0; hit = 2'b00;
  endtask
  task automatic test_write_hit;
    mem_write = 1'b1; hit = 2'b01;
    #1;
    e = 17'b1_0_0_01_00_00_01_1_1_1_0_0_0; checks++;
    if (outs !== e) begin errors++; $display("FAIL write_hit got=%b want=%b", outs, e); end
    tick; n_hit++;
    mem_write = 1'b0; hit = 2'b00;
  endtask
  task automatic test_clean_miss;
    mem_read = 1'b1; hit = 2'b00; lru_way = 1'b1; victim_dirty = 1'b0; cyc = 1;
    #1;
    e = 17'b0_0_0_00_00_00_00_0_0_0_1_0_0; checks++;
    if (outs !== e) begin errors++; $display("FAIL clean_miss_check got=%b want=%b", outs, e); end
    tick; cyc++; n_miss++;
    for (int i = 0; i < 2; i++) begin
      lru_way = 1'b0;
      #1;
      e = 17'b0_1_0_00_00_00_00_0_0_0_1_0_0; checks++;
      if (outs !== e) begin errors++; $display("FAIL clean_alloc_wait%0d got=%b want=%b", i, outs, e); end
      tick; cyc++;
    end
    pmem_resp = 1'b1;
    #1;
    e = 17'b0_1_0_10_10_10_10_0_0_0_1_1_0; checks++;
    if (outs !== e) begin errors++; $display("FAIL clean_install got=%b want=%b", outs, e); end
    tick; cyc++;
    pmem_resp = 1'b0; hit = 2'b10;
    #1;
    e = 17'b1_0_0_00_00_00_00_0_1_0_1_0_0; checks++;
    if (outs !== e) begin errors++; $display("FAIL clean_retry got=%b want=%b", outs, e); end
    checks++;
    if (cyc !== 5) begin errors++; $display("FAIL clean_latency got=%0d want=5", cyc); end
    tick; n_hit++;
    mem_read = 1'b0; hit = 2'b00;
  endtask
  task automatic test_dirty_miss;
    mem_write = 1'b1; hit = 2'b00; lru_way = 1'b0; victim_dirty = 1'b1;
    #1;
    e = 17'b0; checks++;
    if (outs !== e) begin errors++; $display("FAIL dirty_miss_check got=%b want=%b", outs, e); end
    tick; n_miss++;
    victim_dirty = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pmem_resp = (i == 1);
      #1;
      e = 17'b0_0_1_00_00_00_00_0_0_0_0_0_1; checks++;
      if (outs !== e) begin errors++; $display("FAIL dirty_wb%0d got=%b want=%b", i, outs, e); end
      tick;
    end
    n_wb++;
    #1;
    e = 17'b0_1_0_01_01_01_01_0_0_0_0_1_0; checks++;
    if (outs !== e) begin errors++; $display("FAIL dirty_install got=%b want=%b", outs, e); end
    tick;
    pmem_resp = 1'b0; hit = 2'b01;
    #1;
    e = 17'b1_0_0_01_00_00_01_1_1_1_0_0_0; checks++;
    if (outs !== e) begin errors++; $display("FAIL dirty_retry got=%b want=%b", outs, e); end
    tick; n_hit++;
    mem_write = 1'b0; hit = 2'b00;
    ec = PERF ? {16'(n_hit), 16'(n_miss), 16'(n_wb)} : 48'h0;
    checks++;
    if (cnts !== ec) begin errors++; $display("FAIL counters got=%h want=%h", cnts, ec); end
  endtask
  task automatic test_edge_cases;
    pmem_resp = 1'b1; lru_way = 1'b1;
    #1;
    e = 17'b0_0_0_00_00_00_00_0_0_0_1_0_0; checks++;
    if (outs !== e) begin errors++; $display("FAIL pmem_resp_check got=%b want=%b", outs, e); end
    tick;
    #1;
    checks++;
    if (outs !== e) begin errors++; $display("FAIL pmem_resp_after got=%b want=%b", outs, e); end
    pmem_resp = 1'b0;
    mem_read = 1'b1; mem_write = 1'b1; hit = 2'b10;
    #1;
    e = 17'b1_0_0_10_00_00_10_1_1_0_1_0_0; checks++;
    if (outs !== e) begin errors++; $display("FAIL rd_and_wr got=%b want=%b", outs, e); end
    tick; n_hit++;
    mem_read = 1'b0; mem_write = 1'b0; hit = 2'b00;
  endtask
  task automatic test_back_to_back;
    mem_read = 1'b1; hit = 2'b01;
    for (int i = 0; i < 2; i++) begin
      #1;
      e = 17'b1_0_0_00_00_00_00_0_1_1_0_0_0; checks++;
      if (outs !== e) begin errors++; $display("FAIL b2b_hit%0d got=%b want=%b", i, outs, e); end
      tick; n_hit++;
    end
    hit = 2'b00; lru_way = 1'b0; victim_dirty = 1'b0;
    tick; n_miss++;
    mem_read = 1'b0; pmem_resp = 1'b1;
    #1;
    e = 17'b0_1_0_01_01_01_01_0_0_0_0_1_0; checks++;
    if (outs !== e) begin errors++; $display("FAIL drop_install got=%b want=%b", outs, e); end
    tick;
    pmem_resp = 1'b0;
    #1;
    e = 17'b0; checks++;
    if (outs !== e) begin errors++; $display("FAIL drop_idle got=%b want=%b", outs, e); end
    ec = PERF ? {16'(n_hit), 16'(n_miss), 16'(n_wb)} : 48'h0;
    checks++;
    if (cnts !== ec) begin errors++; $display("FAIL counters2 got=%h want=%h", cnts, ec); end
  endtask
  task automatic test_reset_mid_wb;
    mem_read = 1'b1; hit = 2'b00; lru_way = 1'b1; victim_dirty = 1'b1;
    tick;
    #1;
    e = 17'b0_0_1_00_00_00_00_0_0_0_1_0_1; checks++;
    if (outs !== e) begin errors++; $display("FAIL wb_before_reset got=%b want=%b", outs, e); end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (outs !== 17'b0) begin errors++; $display("FAIL reset_mid_wb got=%b want=0", outs); end
    checks++;
    if (cnts !== 48'h0) begin errors++; $display("FAIL reset_mid_wb_cnts got=%h want=0", cnts); end
    tick;
    mem_read = 1'b0; victim_dirty = 1'b0;
    #1 reset_n = 1'b1;
    #1;
    e = 17'b0_0_0_00_00_00_00_0_0_0_1_0_0; checks++;
    if (outs !== e) begin errors++; $display("FAIL post_reset_idle got=%b want=%b", outs, e); end
    tick;
    #1;
    checks++;
    if (outs !== e) begin errors++; $display("FAIL post_reset_idle2 got=%b want=%b", outs, e); end
  endtask
  initial begin
    test_reset;
    test_read_hit;
    test_write_hit;
    test_clean_miss;
    test_dirty_miss;
    test_edge_cases;
    test_back_to_back;
    test_reset_mid_wb;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Control FSM for the 2-way set-associative L1 cache datapath built from the shared `array` blocks: data, tag, valid, dirty and LRU arrays.
- Sequences hit service, dirty-victim writeback and line allocation between the CPU-side handshake and the physical-memory handshake.
- Drives all array write enables and datapath mux selects.
- Purely control: no data or address buses pass through it.

Parameters:
- INDEX_WIDTH, 3, set-index width. Matches array depth 8; used only by the optional counter logic width checks.
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_resp  out  1  one-cycle request-complete pulse
- hit  in  2  per-way tag-match-and-valid from datapath comparators
- lru_way  in  1  LRU bit of the indexed set; equals the replacement way
- victim_dirty  in  1  dirty bit of the way selected by way_sel
- pmem_read  out  1  physical-memory line read strobe
- pmem_write  out  1  physical-memory line write strobe
- pmem_resp  in  1  physical-memory transaction-done pulse
- data_write  out  2  per-way data array write enable
- tag_write  out  2  per-way tag array write enable
- valid_write  out  2  per-way valid array write enable (valid_in tied 1 in datapath)
- dirty_write  out  2  per-way dirty array write enable
- dirty_in  out  1  value written to dirty array
- lru_write  out  1  LRU array write enable
- lru_in  out  1  value written to LRU array
- way_sel  out  1  way routed to read mux, writeback path and victim dirty mux
- data_src_sel  out  1  0 = CPU write merge, 1 = pmem line
- pmem_addr_sel  out  1  0 = CPU address, 1 = victim tag + index
- hit_count, miss_count, wb_count  out  CNT_WIDTH  performance counters (see Optional Feature)

Behaviour:
- States: CHECK (reset/idle), WRITEBACK, ALLOCATE. Encoded as cache_ctrl_state_t.
- Reset (async, reset_n=0):
  - state=CHECK, victim_q=0, counters=0.
  - All outputs 0 combinationally; no pmem strobe survives reset.
- Outputs not listed for a state are 0. Write enables are combinational and take effect at the next rising edge.
- CHECK with no request: all enables 0; way_sel=lru_way.
- CHECK, request, hit (mem_resp asserted same cycle; hit latency 1 cycle):
  - w = 0 if hit[0], else 1; hit=2'b11 is illegal and way 0 wins.
  - way_sel=w; lru_write=1; lru_in=~w.
  - Write hit: data_write[w]=1, data_src_sel=0, dirty_write[w]=1, dirty_in=1.
- CHECK, request, miss (hit=0):
  - way_sel=lru_way; victim_q<=lru_way.
  - Next state WRITEBACK if victim_dirty, else ALLOCATE. mem_resp=0.
- WRITEBACK:
  - pmem_write=1, pmem_addr_sel=1, way_sel=victim_q.
  - On pmem_resp go to ALLOCATE; else hold.
- ALLOCATE:
  - pmem_read=1, pmem_addr_sel=0, way_sel=victim_q.
  - On pmem_resp, same cycle:
    - data_write[victim_q]=1, data_src_sel=1, tag_write[victim_q]=1, valid_write[victim_q]=1.
    - dirty_write[victim_q]=1, dirty_in=0.
    - Go to CHECK. The retry in CHECK then hits and completes the request (write merges there).
- Miss latencies, with pmem_resp arriving after N cycles:
  - Clean miss: mem_resp at cycle N+2 after request.
  - Dirty miss: mem_resp at cycle 2N+2 after request.
- mem_read and mem_write both high: treated as a write.
- Request dropped mid-miss: the current pmem transaction completes and the line is installed; the FSM returns to CHECK idle with no mem_resp.
- pmem_resp in CHECK: ignored.
- pmem_resp on the first cycle of a state: honoured.
- Request held after mem_resp: treated as a new request the next cycle.

Optional Feature:
- Macro CACHE_CTRL_PERF_EN.
- Defined:
  - hit_count increments on each CHECK cycle with request and hit.
  - miss_count increments on each CHECK cycle with request and miss.
  - wb_count increments on each WRITEBACK exit.
  - All counters wrap modulo 2^CNT_WIDTH and reset to 0.
- Undefined: ports remain and are tied to 0; no counter flops are synthesized.

Decomposition:
- In lc3b_types:
  - cache_ctrl_state_t enum {CHECK, WRITEBACK, ALLOCATE}.
  - lc3b_way typedef (1 bit).
  - CACHE_WAYS=2 constant.
- One sub-module, cache_perf_cnt: enable-gated wrapping counter, instantiated three times under CACHE_CTRL_PERF_EN.

Test Plan:
- Reset: reset_n low mid-WRITEBACK with pmem_write=1 -> pmem_write=0 immediately; state CHECK; counters 0.
- Read hit: mem_read=1, hit=2'b10 -> same-cycle mem_resp=1, way_sel=1, lru_write=1, lru_in=0, no data_write.
- Write hit: mem_write=1, hit=2'b01 -> mem_resp=1, data_write=2'b01, dirty_write=2'b01, dirty_in=1, data_src_sel=0.
- Clean miss: mem_read=1, hit=0, lru_way=1, victim_dirty=0; pmem_resp after 3 cycles -> pmem_read high 3 cycles; tag/valid/data_write=2'b10, data_src_sel=1; then hit=2'b10 gives mem_resp at cycle 5.
- Dirty miss: mem_write=1, hit=0, lru_way=0, victim_dirty=1 -> pmem_write with pmem_addr_sel=1 until pmem_resp, then pmem_read; install way 0 with dirty_in=0; retry write sets dirty_in=1; wb_count=1, miss_count=1, hit_count=1 (PERF_EN).
- Edge cases: lru_way toggles during ALLOCATE -> install still targets victim_q. pmem_resp in CHECK -> no effect. Both mem_read and mem_write -> write behaviour.
